// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared constants and types for the frame-buffer rectangle-fill engine.
//   FB_WIDTH / FB_HEIGHT : visible frame-buffer geometry (320x240)
//   ADDR_W               : linear write-address width (addr = y*320 + x)
//   COLOR_W              : pixel colour width ({R,G,B}, 4 bits each)
//   FB_SIZE              : number of pixels; highest valid address is FB_SIZE-1
//   fb_state_e           : fill FSM state encoding
//   row_base_of()        : y*320 built from two shifts, no multiplier
// -----------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int ADDR_W    = 17;
    localparam int COLOR_W   = 12;
    localparam int FB_SIZE   = FB_WIDTH * FB_HEIGHT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } fb_state_e;

    // 320 = 256 + 64, so y*320 = (y<<8) + (y<<6). Max 239*320 = 76480 fits 17 bits.
    function automatic logic [ADDR_W-1:0] row_base_of(input logic [7:0] y);
        return {1'b0, y, 8'b0} + {3'b0, y, 6'b0};
    endfunction

endpackage

// File: rtl/fb_rect_clip.sv
// -----------------------------------------------------------------------------
// fb_rect_clip
// Combinational clip of a fill rectangle against the visible screen.
//   x_i, y_i   : top-left corner (may lie off-screen)
//   w_i, h_i   : requested width / height
//   w_eff_o    : min(w, FB_WIDTH-x), 0 when x is off-screen
//   h_eff_o    : min(h, FB_HEIGHT-y), 0 when y is off-screen
//   empty_o    : nothing to draw (either effective dimension is zero)
// All arithmetic is 10 bit so the remaining-space subtraction never wraps.
// -----------------------------------------------------------------------------
module fb_rect_clip
    import fb_pkg::*;
(
    input  logic [8:0] x_i,
    input  logic [7:0] y_i,
    input  logic [8:0] w_i,
    input  logic [7:0] h_i,
    output logic [9:0] w_eff_o,
    output logic [9:0] h_eff_o,
    output logic       empty_o
);

    localparam logic [9:0] FB_W10 = 10'(FB_WIDTH);
    localparam logic [9:0] FB_H10 = 10'(FB_HEIGHT);

    logic [9:0] x_ext;
    logic [9:0] y_ext;
    logic [9:0] w_ext;
    logic [9:0] h_ext;
    logic [9:0] avail_w;
    logic [9:0] avail_h;

    assign x_ext = {1'b0, x_i};
    assign y_ext = {2'b0, y_i};
    assign w_ext = {1'b0, w_i};
    assign h_ext = {2'b0, h_i};

    // Space left on screen to the right of / below the corner.
    assign avail_w = (x_ext < FB_W10) ? (FB_W10 - x_ext) : 10'd0;
    assign avail_h = (y_ext < FB_H10) ? (FB_H10 - y_ext) : 10'd0;

    assign w_eff_o = (w_ext < avail_w) ? w_ext : avail_w;
    assign h_eff_o = (h_ext < avail_h) ? h_ext : avail_h;
    assign empty_o = (w_eff_o == 10'd0) || (h_eff_o == 10'd0);

endmodule

// File: rtl/fb_fill_engine.sv
// -----------------------------------------------------------------------------
// fb_fill_engine
// Rectangle-fill engine driving the frame buffer's CPU write port. Accepts one
// command over a valid/ready handshake, clips it to the screen and issues one
// write per un-stalled cycle, row by row, left to right.
//   clk_cpu, reset_n      : clock, asynchronous active-low reset
//   cmd_valid / cmd_ready : command handshake (ready only while idle)
//   cmd_x, cmd_y          : top-left corner
//   cmd_w, cmd_h          : size in pixels / rows
//   cmd_color             : fill colour
//   fb_wait               : arbiter stall, suppresses the write strobe
//   fb_write              : write strobe (a write happens every cycle it is high)
//   fb_addr, fb_wdata     : registered write address / data ({20'b0, colour})
//   busy                  : command in progress (SETUP, FILL, DONE)
//   done                  : one-cycle pulse when a command completes
// -----------------------------------------------------------------------------
module fb_fill_engine
    import fb_pkg::*;
(
    input  logic               clk_cpu,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [8:0]         cmd_x,
    input  logic [7:0]         cmd_y,
    input  logic [8:0]         cmd_w,
    input  logic [7:0]         cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    input  logic               fb_wait,
    output logic               fb_write,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [31:0]        fb_wdata,
    output logic               busy,
    output logic               done
);

    fb_state_e          state_q;
    logic [8:0]         x_q;
    logic [7:0]         y_q;
    logic [8:0]         w_q;
    logic [7:0]         h_q;
    logic [COLOR_W-1:0] wdata_q;
    logic [ADDR_W-1:0]  row_base_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [8:0]         col_q;
    logic [7:0]         row_q;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;

    logic [9:0]         w_eff;
    logic [9:0]         h_eff;
    logic               clip_empty;

    logic [ADDR_W-1:0]  setup_base_d;
    logic [ADDR_W-1:0]  next_row_base_d;
    logic               more_cols_d;
    logic               more_rows_d;

    // Latched command fields are stable for the whole command, so the clip
    // results can be used directly in both SETUP and FILL.
    fb_rect_clip u_clip (
        .x_i     (x_q),
        .y_i     (y_q),
        .w_i     (w_q),
        .h_i     (h_q),
        .w_eff_o (w_eff),
        .h_eff_o (h_eff),
        .empty_o (clip_empty)
    );

    assign setup_base_d    = row_base_of(y_q);
    assign next_row_base_d = row_base_q + ADDR_W'(FB_WIDTH);

    // Only evaluated in FILL, where w_eff and h_eff are both non-zero.
    assign more_cols_d = ({1'b0, col_q} < (w_eff - 10'd1));
    assign more_rows_d = ({2'b0, row_q} < (h_eff - 10'd1));

    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            wdata_q    <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid && ready_q) begin
                        x_q     <= cmd_x;
                        y_q     <= cmd_y;
                        w_q     <= cmd_w;
                        h_q     <= cmd_h;
                        wdata_q <= cmd_color;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end
                end

                SETUP: begin
                    if (clip_empty) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        row_base_q <= setup_base_d;
                        addr_q     <= setup_base_d + {8'b0, x_q};
                        col_q      <= '0;
                        row_q      <= '0;
                        state_q    <= FILL;
                    end
                end

                FILL: begin
                    // A stalled cycle leaves address and counters untouched.
                    if (!fb_wait) begin
                        if (more_cols_d) begin
                            addr_q <= addr_q + ADDR_W'(1);
                            col_q  <= col_q + 9'd1;
                        end else if (more_rows_d) begin
                            row_base_q <= next_row_base_d;
                            addr_q     <= next_row_base_d + {8'b0, x_q};
                            col_q      <= '0;
                            row_q      <= row_q + 8'd1;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end

                DONE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The strobe must drop in the same cycle the arbiter stalls, so it is
    // decoded from the state rather than registered.
    assign fb_write  = (state_q == FILL) && !fb_wait;
    assign fb_addr   = addr_q;
    assign fb_wdata  = {{(32-COLOR_W){1'b0}}, wdata_q};
    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_fb_fill_engine.sv
module tb_fb_fill_engine;
    import fb_pkg::*;

    logic               clk_cpu = 1'b0;
    logic               reset_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [8:0]         cmd_x;
    logic [7:0]         cmd_y;
    logic [8:0]         cmd_w;
    logic [7:0]         cmd_h;
    logic [COLOR_W-1:0] cmd_color;
    logic               fb_wait;
    logic               fb_write;
    logic [ADDR_W-1:0]  fb_addr;
    logic [31:0]        fb_wdata;
    logic               busy;
    logic               done;

    fb_fill_engine dut (
        .clk_cpu   (clk_cpu),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .fb_wait   (fb_wait),
        .fb_write  (fb_write),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk_cpu = ~clk_cpu;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int done_cyc[$];
    int stall_viol = 0;
    int max_addr   = 0;
    bit rand_wait  = 1'b0;

    int exp_basic[4]  = '{0, 1, 320, 321};
    int exp_stall[12] = '{1610, 1611, 1612, 1613, 1930, 1931, 1932, 1933, 2250, 2251, 2252, 2253};
    int exp_hs[5]     = '{325, 326, 327, 740, 1060};

    always @(posedge clk_cpu) cyc = cyc + 1;

    // Arbiter model: random stalls only while enabled.
    always @(posedge clk_cpu) begin
        #1;
        fb_wait = rand_wait && ($urandom_range(0, 1) == 1);
    end

    // Write/done monitor: the strobe is stable from posedge+1 to the next posedge.
    always @(negedge clk_cpu) begin
        if (fb_write) begin
            wr_addr.push_back(int'(fb_addr));
            wr_data.push_back(int'(fb_wdata));
            wr_cyc.push_back(cyc);
            if (fb_wait) stall_viol++;
            if (int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
        end
        if (done) done_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
        end
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc.delete();
        stall_viol = 0;
    endtask

    task automatic send(input int x, input int y, input int w, input int h, input int col,
                        output int acc);
        @(posedge clk_cpu); #1;
        cmd_x     = 9'(x);
        cmd_y     = 8'(y);
        cmd_w     = 9'(w);
        cmd_h     = 8'(h);
        cmd_color = COLOR_W'(col);
        cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 200 && acc < 0; i++) begin
            @(negedge clk_cpu);
            if (cmd_ready) acc = cyc;
        end
        @(posedge clk_cpu); #1;
        cmd_valid = 1'b0;
        chk("accept", (acc >= 0), 1);
        $display("cmd x=%0d y=%0d w=%0d h=%0d col=0x%0h accepted in cycle %0d", x, y, w, h, col, acc);
    endtask

    // Returns at negedge+1 of the cycle where the target done count is reached.
    task automatic wait_done(input int target, input int limit, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk_cpu); #1;
            if (done_cyc.size() >= target) hit = 1'b1;
        end
        chk(tag, hit, 1);
    endtask

    initial begin
        int acc;
        int acc_b;
        bit hit;

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_x     = '0;
        cmd_y     = '0;
        cmd_w     = '0;
        cmd_h     = '0;
        cmd_color = '0;

        // Reset state
        repeat (2) @(negedge clk_cpu);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_write", fb_write, 0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_wdata", fb_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk_cpu); #1;
        reset_n = 1'b1;
        repeat (2) @(negedge clk_cpu);

        // Basic 2x2 fill
        clear_log();
        send(0, 0, 2, 2, 'hF00, acc);
        wait_done(1, 50, "basic_tmo");
        chk("basic_busy_at_done", busy, 1);
        chk("basic_ready_at_done", cmd_ready, 0);
        chk("basic_nwr", wr_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk("basic_addr", wr_addr[i], exp_basic[i]);
            chk("basic_wdata", wr_data[i], 32'h0000_0F00);
        end
        chk("basic_first_cyc", wr_cyc[0], acc + 2);
        chk("basic_last_cyc", wr_cyc[3], acc + 5);
        chk("basic_done_cyc", done_cyc[0], acc + 6);
        @(negedge clk_cpu);
        chk("basic_ready_back", cmd_ready, 1);
        chk("basic_busy_clear", busy, 0);
        chk("basic_done_pulse", done, 0);

        // Corner clip
        clear_log();
        send(318, 239, 5, 3, 'h0F0, acc);
        wait_done(1, 50, "corner_tmo");
        chk("corner_nwr", wr_addr.size(), 2);
        chk("corner_addr0", wr_addr[0], 76798);
        chk("corner_addr1", wr_addr[1], 76799);
        chk("corner_wdata", wr_data[1], 32'h0000_00F0);
        chk("corner_done_cyc", done_cyc[0], acc + 4);

        // Degenerate: zero width, then x off-screen, then y off-screen
        clear_log();
        send(10, 10, 0, 5, 'h111, acc);
        wait_done(1, 20, "degen_w0_tmo");
        chk("degen_w0_done_cyc", done_cyc[0], acc + 2);
        clear_log();
        send(320, 0, 4, 4, 'h222, acc);
        wait_done(1, 20, "degen_x320_tmo");
        chk("degen_x320_done_cyc", done_cyc[0], acc + 2);
        clear_log();
        send(0, 240, 4, 4, 'h333, acc);
        wait_done(1, 20, "degen_y240_tmo");
        chk("degen_y240_done_cyc", done_cyc[0], acc + 2);
        repeat (3) @(negedge clk_cpu);
        chk("degen_nwr", wr_addr.size(), 0);

        // Stalled 4x3 fill
        clear_log();
        rand_wait = 1'b1;
        send(10, 5, 4, 3, 'h00F, acc);
        wait_done(1, 500, "stall_tmo");
        rand_wait = 1'b0;
        chk("stall_nwr", wr_addr.size(), 12);
        for (int i = 0; i < 12; i++) chk("stall_addr", wr_addr[i], exp_stall[i]);
        chk("stall_wdata", wr_data[11], 32'h0000_000F);
        chk("stall_viol", stall_viol, 0);
        repeat (2) @(negedge clk_cpu);

        // Handshake: second command held valid during busy
        clear_log();
        @(posedge clk_cpu); #1;
        cmd_x = 9'd5; cmd_y = 8'd1; cmd_w = 9'd3; cmd_h = 8'd1; cmd_color = 12'h5A5;
        cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 50 && acc < 0; i++) begin
            @(negedge clk_cpu);
            if (cmd_ready) acc = cyc;
        end
        @(posedge clk_cpu); #1;
        cmd_x = 9'd100; cmd_y = 8'd2; cmd_w = 9'd1; cmd_h = 8'd2; cmd_color = 12'h0A5;
        acc_b = -1;
        for (int i = 0; i < 50 && acc_b < 0; i++) begin
            @(negedge clk_cpu);
            if (cmd_ready) acc_b = cyc;
        end
        @(posedge clk_cpu); #1;
        cmd_valid = 1'b0;
        $display("handshake: cmd A accepted cycle %0d, cmd B accepted cycle %0d", acc, acc_b);
        wait_done(2, 50, "hs_tmo");
        chk("hs_a_done_cyc", done_cyc[0], acc + 5);
        chk("hs_b_accept_cyc", acc_b, acc + 6);
        chk("hs_b_done_cyc", done_cyc[1], acc_b + 4);
        chk("hs_nwr", wr_addr.size(), 5);
        for (int i = 0; i < 5; i++) chk("hs_addr", wr_addr[i], exp_hs[i]);
        chk("hs_a_wdata", wr_data[0], 32'h0000_05A5);
        chk("hs_b_wdata", wr_data[4], 32'h0000_00A5);
        repeat (2) @(negedge clk_cpu);

        // Reset during a 10x10 fill, after the third write
        clear_log();
        send(0, 0, 10, 10, 'h123, acc);
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk_cpu); #1;
            if (wr_addr.size() >= 3) hit = 1'b1;
        end
        chk("rstmid_tmo", hit, 1);
        @(posedge clk_cpu); #1;
        reset_n = 1'b0;
        #1;
        chk("rstmid_write", fb_write, 0);
        chk("rstmid_ready", cmd_ready, 1);
        chk("rstmid_busy", busy, 0);
        repeat (3) @(negedge clk_cpu);
        @(posedge clk_cpu); #1;
        reset_n = 1'b1;
        repeat (3) @(negedge clk_cpu);
        chk("rstmid_nwr", wr_addr.size(), 3);
        chk("rstmid_addr2", wr_addr[2], 2);
        chk("rstmid_ndone", done_cyc.size(), 0);
        chk("rstmid_ready_after", cmd_ready, 1);
        chk("rstmid_addr_after", fb_addr, 0);

        // New command after reset
        clear_log();
        send(1, 1, 1, 1, 'hABC, acc);
        wait_done(1, 20, "post_rst_tmo");
        chk("post_rst_nwr", wr_addr.size(), 1);
        chk("post_rst_addr", wr_addr[0], 321);
        chk("post_rst_wdata", wr_data[0], 32'h0000_0ABC);
        chk("post_rst_done_cyc", done_cyc[0], acc + 3);

        chk("addr_bound", (max_addr <= FB_SIZE - 1), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
